// File: rtl/ss_stream_decoder.sv
// Stochastic-to-binary converter: counts ones in a 2^WIN_LOG2 valid-bit window and
// presents the scaled 0.WIDTH fixed-point result on a valid/ready handshake.
module ss_stream_decoder #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned WIN_LOG2 = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic                x_ss,
   input  logic                x_valid,
   output logic                busy,
   output logic                z_valid,
   input  logic                z_ready,
   output logic [WIDTH-1:0]    z_binary,
   output logic [WIN_LOG2:0]   z_ones
);

   localparam int unsigned Shift = WIN_LOG2 - WIDTH;
   localparam logic [WIN_LOG2:0] WinLen = {1'b1, {WIN_LOG2{1'b0}}};

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   state_e              state_q, state_d;
   logic [WIN_LOG2:0]   ones_q, ones_d;
   logic [WIN_LOG2:0]   samp_q, samp_d;
   logic [WIDTH-1:0]    zbin_q, zbin_d;
   logic [WIN_LOG2:0]   zones_q, zones_d;

   logic [WIN_LOG2:0]   ones_inc;
   logic [WIN_LOG2:0]   samp_inc;
   logic [WIN_LOG2:0]   ones_shr;

   always_comb begin
      ones_inc = ones_q + {{WIN_LOG2{1'b0}}, x_ss};
      samp_inc = samp_q + {{WIN_LOG2{1'b0}}, 1'b1};
      ones_shr = ones_inc >> Shift;
   end

   always_comb begin
      state_d = state_q;
      ones_d  = ones_q;
      samp_d  = samp_q;
      zbin_d  = zbin_q;
      zones_d = zones_q;
      if (abort) begin
         state_d = StIdle;
         ones_d  = '0;
         samp_d  = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_d = StAccum;
                  ones_d  = '0;
                  samp_d  = '0;
               end
            end
            StAccum: begin
               if (x_valid) begin
                  ones_d = ones_inc;
                  samp_d = samp_inc;
                  if (samp_inc == WinLen) begin
                     state_d = StDone;
                     zones_d = ones_inc;
                     // A full window of ones is 1.0, which 0.WIDTH cannot hold: saturate.
                     zbin_d  = ones_inc[WIN_LOG2] ? {WIDTH{1'b1}} : ones_shr[WIDTH-1:0];
                  end
               end
            end
            StDone: begin
               if (z_ready) begin
                  state_d = start ? StAccum : StIdle;
                  ones_d  = '0;
                  samp_d  = '0;
               end
            end
            default: begin
               state_d = StIdle;
               ones_d  = '0;
               samp_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         ones_q  <= '0;
         samp_q  <= '0;
         zbin_q  <= '0;
         zones_q <= '0;
      end else begin
         state_q <= state_d;
         ones_q  <= ones_d;
         samp_q  <= samp_d;
         zbin_q  <= zbin_d;
         zones_q <= zones_d;
      end
   end

   always_comb begin
      busy     = (state_q == StAccum);
      z_valid  = (state_q == StDone);
      z_binary = zbin_q;
      z_ones   = zones_q;
   end

endmodule

// File: doc/ss_stream_decoder.md
# ss_stream_decoder

Stochastic-to-binary converter: the receiving end for the unipolar stochastic streams produced by the binary-to-stochastic generators and the arithmetic blocks (divider, multiplier). It counts the 1s in one serial stochastic bit stream over a fixed window of 2^WIN_LOG2 valid bits. It then scales the count to a WIDTH-bit unsigned binary value and presents it on a valid/ready output handshake. A start/abort control lets a controller frame measurement windows back-to-back.

## Interface
- WIDTH, 8: bit width of the binary result; the result represents ones/2^WIN_LOG2 in 0.WIDTH unsigned fixed point.
- WIN_LOG2, 8: log2 of the window length in valid stream bits; legal range WIN_LOG2 >= WIDTH.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a new window; honoured only as described under Operation.
- abort  input  1  synchronous abort; returns to IDLE and discards any partial or pending result.
- x_ss  input  1  stochastic stream bit.
- x_valid  input  1  x_ss is sampled only when high; low cycles are stalls and are not counted.
- busy  output  1  high in ACCUM.
- z_valid  output  1  result available; high in DONE.
- z_ready  input  1  consumer accepts the result when z_valid and z_ready are both high.
- z_binary  output  WIDTH  scaled result; stable while z_valid is high.
- z_ones  output  WIN_LOG2+1  raw ones count of the last completed window; stable while z_valid is high.

## Operation
- Registers:
  - ones counter, WIN_LOG2+1 bits.
  - sample counter, WIN_LOG2+1 bits.
  - 2-bit state.
  - result registers z_binary and z_ones.
- FSM states:
  - IDLE: start=1 moves to ACCUM and clears both counters. The stream bit in the start cycle is not counted.
  - ACCUM: each cycle with x_valid=1, sample counter += 1 and ones counter += x_ss. When this increment makes the sample count reach 2^WIN_LOG2, the state moves to DONE and the result registers load from the final ones count, which includes that last bit. start is ignored in ACCUM.
  - DONE: z_valid=1. On z_valid&z_ready, go to IDLE. If start=1 in the same cycle as the accept, go directly to ACCUM with cleared counters. start without z_ready is ignored and the result is held.
- Scaling:
  - If ones == 2^WIN_LOG2, z_binary = all ones (2^WIDTH-1). This saturation exists because 1.0 is not representable.
  - Otherwise z_binary = ones >> (WIN_LOG2-WIDTH), truncating with no rounding.
- abort:
  - Has priority over start, x_valid and z_ready in every state.
  - Next state is IDLE, with counters cleared and z_valid=0.
  - z_binary and z_ones keep their last values; they are don't-care while z_valid=0.
- Counters cannot overflow: the sample counter stops at 2^WIN_LOG2, and ones <= samples.

## Timing
- Reset values: state IDLE, busy 0, z_valid 0, z_binary 0, z_ones 0, both counters 0.
- Reset mid-window or mid-DONE: immediate loss of state and result, with no output pulse.
- Window latency:
  - start is sampled at edge t0, and busy=1 from t0.
  - The edge sampling the 2^WIN_LOG2-th valid bit sets z_valid=1 and busy=0 after that same edge.
  - With x_valid tied high and WIN_LOG2=8, z_valid rises 256 cycles after the start edge.
- Throughput:
  - The back-to-back start on accept costs zero idle cycles. The first bit of the next window is the one presented on the cycle after the accept edge.
  - Maximum rate is one window per 2^WIN_LOG2 + 1 cycles.
- z_binary and z_ones are registered outputs and change only on the edge that enters DONE.
- Simultaneous events:
  - Last-bit completion coincident with abort: abort wins, and z_valid stays 0.
  - start in IDLE coincident with abort: the FSM stays in IDLE.

## Test plan
- All-ones stream, x_valid=1, WIN_LOG2=WIDTH=8, start one pulse: z_valid rises 256 cycles after the start edge, with z_ones=256 and z_binary=0xFF. Then z_ready=1 for one cycle returns the block to IDLE with z_valid=0.
- Alternating 1/0 stream: z_ones=128, z_binary=0x80. An all-zeros stream gives z_ones=0, z_binary=0x00.
- Stream of 64 ones followed by 192 zeros, with x_valid low on every third cycle and zero-valued x_ss=1 glitches during the stalls: z_ones=64, z_binary=0x40, and z_valid arrives after 256 valid samples.
- Hold z_ready=0 for 20 cycles after z_valid while pulsing start and changing x_ss: z_valid, z_binary and z_ones stay constant.
- Then assert z_ready and start together: z_valid drops, busy=1 on the next cycle, and the second window completes 256 valid samples later with its own count.
- Abort at sample 100, and separately assert rst low at sample 100: busy=0 and z_valid=0 next cycle (immediately for rst). A fresh start with an all-ones stream then yields 0xFF, proving no residual count.
- Parameter run with WIDTH=6, WIN_LOG2=8 and 200 ones in the window: z_ones=200, z_binary=50. With 256 ones, z_binary=63 (saturated).
